// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: holds one 7-bit segment pattern per digit and scans them
// onto a shared active-low segment bus with active-low one-hot digit anodes.
// Optional anti-ghosting blanking is enabled by defining SEG7_BLANK_EN; it
// turns the anodes off for the first BLANK_CYC cycles of every slot.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int ADDR_W     = 2,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [6:0]            wr_seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  digit_tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

`ifdef SEG7_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic [6:0]    pat [NUM_DIGITS];
    logic [PW-1:0] presc, presc_next;
    logic [IW-1:0] idx, idx_next;
    logic          last;
    logic          wr_hit;
    logic          blank;
    logic [6:0]    shown;

    // Next-state for the scan counters plus the pattern that will be shown,
    // with a same-cycle write bypassed straight onto the output.
    always_comb begin
        last       = (presc == PW'(DIV - 1));
        presc_next = last ? '0 : presc + 1'b1;
        idx_next   = idx;
        if (last)
            idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        wr_hit = wr_en && (32'(wr_addr) < NUM_DIGITS);
        shown  = pat[idx_next];
        if (wr_hit && (32'(wr_addr) == 32'(idx_next)))
            shown = wr_seg;
        blank = BLANK_ON && (32'(presc_next) < BLANK_CYC);
    end

    // Pattern buffer; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                pat[i] <= 7'h00;
        end else if (wr_hit) begin
            pat[wr_addr[IW-1:0]] <= wr_seg;
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= presc_next;
            idx   <= idx_next;
        end
    end

    // Registered pin drivers, all from next-state values so they change on
    // the same edge as the index they reflect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            seg        <= 7'h7F;
            digit_tick <= 1'b0;
        end else begin
            digit_tick <= last;
            if (blank) begin
                an  <= '1;
                seg <= 7'h7F;
            end else begin
                an  <= ~(NUM_DIGITS'(1) << idx_next);
                seg <= ~shown;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit and a 3-digit instance share the write
// port; expected pins are derived from the edge count since reset release
// (slot = k / DIV, position in slot = k % DIV) and a plain array of patterns.
module tb_seg7_scan_driver;

`ifdef SEG7_BLANK_EN
    localparam int DIV     = 8;
    localparam int BLK     = 2;
    localparam int BLK_EFF = 2;
`else
    localparam int DIV     = 4;
    localparam int BLK     = 2;
    localparam int BLK_EFF = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [6:0] wr_seg = 7'h00;
    logic [3:0] an4;
    logic [6:0] seg4;
    logic       tk4;
    logic [2:0] an3;
    logic [6:0] seg3;
    logic       tk3;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .ADDR_W(2), .DIV(DIV), .BLANK_CYC(BLK)) dut4 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_seg(wr_seg),
        .an(an4), .seg(seg4), .digit_tick(tk4));

    seg7_scan_driver #(.NUM_DIGITS(3), .ADDR_W(2), .DIV(DIV), .BLANK_CYC(BLK)) dut3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_seg(wr_seg),
        .an(an3), .seg(seg3), .digit_tick(tk3));

    int n_chk = 0;
    int n_err = 0;
    int k = 0;
    logic [6:0] m4 [4];
    logic [6:0] m3 [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @k=%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic clear_model();
        k = 0;
        for (int i = 0; i < 4; i++) m4[i] = 7'h00;
        for (int i = 0; i < 3; i++) m3[i] = 7'h00;
    endtask

    // Expected pins after k edges since reset release.
    task automatic check_all();
        logic [7:0] ea4, ea3;
        logic [6:0] es4, es3;
        logic       et, blank;
        int         d4, d3;
        et    = (k > 0) && (k % DIV == 0);
        blank = (k == 0) || ((k % DIV) < BLK_EFF);
        ea4 = 8'hFF; ea3 = 8'hFF; es4 = 7'h7F; es3 = 7'h7F;
        if (!blank) begin
            d4  = (k / DIV) % 4;
            d3  = (k / DIV) % 3;
            ea4 = ~(8'd1 << d4);
            ea3 = ~(8'd1 << d3);
            es4 = ~m4[d4];
            es3 = ~m3[d3];
        end
        chk("an4",  32'(an4),  32'(ea4[3:0]));
        chk("seg4", 32'(seg4), 32'(es4));
        chk("tick4", 32'(tk4), 32'(et));
        chk("an3",  32'(an3),  32'(ea3[2:0]));
        chk("seg3", 32'(seg3), 32'(es3));
        chk("tick3", 32'(tk3), 32'(et));
    endtask

    task automatic tick_edge();
        @(posedge clk);
        if (reset) begin
            clear_model();
        end else begin
            k++;
            if (wr_en) begin
                m4[wr_addr] = wr_seg;
                if (wr_addr < 2'd3) m3[wr_addr] = wr_seg;
            end
        end
        #1 check_all();
    endtask

    task automatic set_wr(input logic e, input logic [1:0] a, input logic [6:0] s);
        wr_en = e; wr_addr = a; wr_seg = s;
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 clear_model();
        check_all();
        set_wr(1'b0, 2'd0, 7'h00);
        repeat (2) tick_edge();
        @(negedge clk);
        reset = 1'b0;
        #1 check_all();
    endtask

    initial begin
        clear_model();
        repeat (2) tick_edge();
        @(negedge clk);
        reset = 1'b0;
        #1 check_all();

        // Scan order with the classic 0..3 patterns
        set_wr(1'b1, 2'd0, 7'h3F); tick_edge();
        set_wr(1'b1, 2'd1, 7'h06); tick_edge();
        set_wr(1'b1, 2'd2, 7'h5B); tick_edge();
        set_wr(1'b1, 2'd3, 7'h4F); tick_edge();
        set_wr(1'b0, 2'd0, 7'h00);
        repeat (5 * DIV) tick_edge();

        // Write bypass mid-slot of digit 2
        for (int i = 0; i < 8 * DIV; i++) begin
            if (((k + 1) / DIV) % 4 == 2 && (k + 1) % DIV == DIV - 1) break;
            tick_edge();
        end
        set_wr(1'b1, 2'd2, 7'h7F); tick_edge();
        set_wr(1'b0, 2'd0, 7'h00); repeat (2) tick_edge();

        // Address 3 is out of range for the 3-digit instance
        set_wr(1'b1, 2'd3, 7'h7F); repeat (2) tick_edge();
        set_wr(1'b0, 2'd0, 7'h00); repeat (4 * DIV) tick_edge();

        // Write landing on the 0->1 slot change
        for (int i = 0; i < 8 * DIV; i++) begin
            if ((k + 1) % (4 * DIV) == DIV) break;
            tick_edge();
        end
        set_wr(1'b1, 2'd1, 7'h06); tick_edge();
        set_wr(1'b1, 2'd1, 7'h00);
        for (int i = 0; i < 12 * DIV; i++) begin
            if ((k + 1) % (3 * DIV) == DIV) break;
            tick_edge();
        end
        set_wr(1'b1, 2'd1, 7'h55); tick_edge();
        set_wr(1'b0, 2'd0, 7'h00); repeat (DIV) tick_edge();

        async_reset();
        repeat (3 * DIV) tick_edge();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            set_wr(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 7'($urandom));
            if ($urandom_range(0, 199) == 0) async_reset();
            else tick_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the 7-bit segment-pattern registers.
- Holds one 7-bit pattern per digit and time-multiplexes them onto a shared active-low segment bus with active-low digit anodes.
- Sits between the segment registers/decoders and the board's multiplexed seven-segment display pins.
- Upstream writes patterns through a simple write port; the block free-runs the refresh scan.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- ADDR_W, 2, width of wr_addr; must satisfy 2^ADDR_W >= NUM_DIGITS.
- DIV, 50000, clk cycles per digit slot; minimum 2.
- BLANK_CYC, 4, anode-off cycles at start of each slot (used only with SEG7_BLANK_EN); must be < DIV.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- wr_en, input, 1, write strobe; one pattern accepted per cycle while high.
- wr_addr, input, ADDR_W, digit index to write.
- wr_seg, input, 7, pattern {g,f,e,d,c,b,a}; 1 = segment lit.
- an, output, NUM_DIGITS, digit anodes, active-low, one-hot-low.
- seg, output, 7, segment cathodes, active-low (seg = ~pattern).
- digit_tick, output, 1, one-cycle pulse marking the first cycle of each new slot.

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-high, named reset. All state registers clear immediately on reset assertion.
- Reset values:
  - all buffer entries 7'b0000000
  - prescaler 0, idx 0
  - an all ones (all digits off)
  - seg 7'h7F
  - digit_tick 0
- Write port:
  - On a rising edge with wr_en=1 and wr_addr < NUM_DIGITS, buf[wr_addr] <= wr_seg.
  - wr_addr >= NUM_DIGITS: write ignored, no state change.
  - No backpressure; writes are always accepted.
- Prescaler:
  - Counts 0..DIV-1, then wraps to 0.
  - idx advances only at the edge where the prescaler equals DIV-1.
  - idx wraps from NUM_DIGITS-1 to 0.
- Registered outputs, all updated on the same edge from next-state values:
  - an <= ~(1 << idx_next); seg <= ~buf_next[idx_next].
  - Write bypass: a write to the displayed digit appears on seg at the same edge the buffer updates, giving zero extra latency.
  - First edge after reset release: an = ~1 (digit 0 on), seg = 7'h7F.
- digit_tick:
  - Goes high for exactly one cycle, starting at the edge where idx advances; it is high during the first cycle of the new slot.
  - Period is DIV cycles.
  - No tick on the first slot after reset.
- Simultaneous write and slot change: the write commits, and seg shows the new idx's pattern including that write if addresses match.
- Reset mid-slot: outputs return to reset values immediately. The scan restarts at digit 0 with a full DIV-cycle slot; buffer contents are lost.

Optional Feature:
- Macro: SEG7_BLANK_EN (anti-ghosting blanking).
- Defined:
  - For prescaler values 0..BLANK_CYC-1 of every slot, an = all ones and seg = 7'h7F.
  - The anode is driven only for the remaining DIV-BLANK_CYC cycles.
  - digit_tick timing is unchanged.
  - The blank interval also applies to the first slot after reset.
- Undefined: no blanking; the anode is active for the full slot. BLANK_CYC is ignored.

Test Plan:
- Reset check: assert reset mid-cycle asynchronously -> an=4'b1111, seg=7'h7F, digit_tick=0 with no clock edge required; first edge after release -> an=4'b1110, seg=7'h7F.
- Scan order (DIV=4, NUM_DIGITS=4):
  - Stimulus: write buf0..3 = 7'h3F, 7'h06, 7'h5B, 7'h4F.
  - Required: an sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; seg = 7'h40, 7'h79, 7'h24, 7'h30.
  - Required: digit_tick pulses every 4 cycles, coincident with each an change.
- Write bypass: while digit 2 is displayed, write addr 2 = 7'h7F -> seg becomes 7'h00 at the same edge the buffer updates; an is unchanged.
- Out-of-range write (NUM_DIGITS=3, ADDR_W=2): write addr 3 = 7'h7F -> no buffer or output change.
- Simultaneous write and slot change: write addr 1 = 7'h06 on the wrap edge 0->1 -> seg = 7'h79 in the first cycle of slot 1.
- SEG7_BLANK_EN (DIV=8, BLANK_CYC=2): each slot shows an=all ones for 2 cycles, then the digit's anode for 6 cycles; digit_tick period stays 8.
